// File: rtl/conv_bcd_bin_seq.sv
// conv_bcd_bin_seq: sequential packed-BCD to unsigned-binary converter.
// One multiply-by-10-and-add step per clock, MSD first, valid/ready on both sides.
// Optional nibble validity check enabled by defining CONV_BCD_CHECK_EN.
module conv_bcd_bin_seq #(
  parameter int N_DIGITS = 2,
  parameter int BIN_W    = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] dato_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      dato_bin,
  output logic                  err,
  output logic                  ovf
);

  localparam int BCD_W  = 4 * N_DIGITS;
  localparam int STEP_W = BIN_W + 4;
  localparam int CNT_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BCD_W-1:0]     bcd_q;
  logic [BIN_W-1:0]     acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_st_q;
  logic                 err_st_q;
  logic [BIN_W-1:0]     dato_bin_q;
  logic                 err_q;
  logic                 ovf_q;

  logic [STEP_W-1:0]    step;
  logic                 step_ovf;
  logic                 err_at_accept;

  // acc*10 + digit at BIN_W+4 bits, built from shifts so no multiplier is needed.
  function automatic logic [STEP_W-1:0] mul10_add(input logic [BIN_W-1:0] acc,
                                                  input logic [3:0]       dig);
    logic [STEP_W-1:0] a;
    a = STEP_W'(acc);
    return (a << 3) + (a << 1) + STEP_W'(dig);
  endfunction

  // Saturate the result to all ones when the word was invalid or overflowed.
  function automatic logic [BIN_W-1:0] sat_result(input logic [BIN_W-1:0] acc,
                                                  input logic             bad);
    return bad ? {BIN_W{1'b1}} : acc;
  endfunction

`ifdef CONV_BCD_CHECK_EN
  // Flag any nibble outside 0..9.
  function automatic logic nib_bad(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign err_at_accept = nib_bad(dato_bcd);
`else
  assign err_at_accept = 1'b0;
`endif

  // The MSD of the remaining word always sits in the top nibble of bcd_q.
  assign step     = mul10_add(acc_q, bcd_q[BCD_W-1 -: 4]);
  assign step_ovf = |step[STEP_W-1:BIN_W];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CONV;
      end
      CONV: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch at accept, one digit per CONV cycle, load outputs on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_st_q   <= 1'b0;
      err_st_q   <= 1'b0;
      dato_bin_q <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bcd_q    <= dato_bcd;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_st_q <= 1'b0;
            err_st_q <= err_at_accept;
          end
        end
        CONV: begin
          acc_q <= step[BIN_W-1:0];
          bcd_q <= bcd_q << 4;
          cnt_q <= cnt_q + CNT_W'(1);
          if (step_ovf) ovf_st_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            dato_bin_q <= sat_result(step[BIN_W-1:0], err_st_q | ovf_st_q | step_ovf);
            err_q      <= err_st_q;
            ovf_q      <= ovf_st_q | step_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign dato_bin = dato_bin_q;
  assign ovf      = ovf_q;
`ifdef CONV_BCD_CHECK_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_conv_bcd_bin_seq.sv
// Directed bench for conv_bcd_bin_seq: three instances (N=2/7b, N=4/14b, N=3/7b).
module tb_conv_bcd_bin_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // N_DIGITS=2, BIN_W=7
  logic       iv2, ir2, ov2, or2, err2, ovf2;
  logic [7:0] bcd2;
  logic [6:0] bin2;
  // N_DIGITS=4, BIN_W=14
  logic        iv4, ir4, ov4, or4, err4, ovf4;
  logic [15:0] bcd4;
  logic [13:0] bin4;
  // N_DIGITS=3, BIN_W=7
  logic        iv3, ir3, ov3, or3, err3, ovf3;
  logic [11:0] bcd3;
  logic [6:0]  bin3;

  conv_bcd_bin_seq #(.N_DIGITS(2), .BIN_W(7)) u2 (
    .clk(clk), .reset(rst), .in_valid(iv2), .in_ready(ir2), .dato_bcd(bcd2),
    .out_valid(ov2), .out_ready(or2), .dato_bin(bin2), .err(err2), .ovf(ovf2));

  conv_bcd_bin_seq #(.N_DIGITS(4), .BIN_W(14)) u4 (
    .clk(clk), .reset(rst), .in_valid(iv4), .in_ready(ir4), .dato_bcd(bcd4),
    .out_valid(ov4), .out_ready(or4), .dato_bin(bin4), .err(err4), .ovf(ovf4));

  conv_bcd_bin_seq #(.N_DIGITS(3), .BIN_W(7)) u3 (
    .clk(clk), .reset(rst), .in_valid(iv3), .in_ready(ir3), .dato_bcd(bcd3),
    .out_valid(ov3), .out_ready(or3), .dato_bin(bin3), .err(err3), .ovf(ovf3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word to u2, return edges from accept until out_valid (capped at 20).
  task automatic start2(input logic [7:0] b, output int cyc);
    iv2  = 1'b1;
    bcd2 = b;
    tick();
    iv2  = 1'b0;
    bcd2 = 8'hEE;
    cyc  = 0;
    while (!ov2 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release2();
    or2 = 1'b1;
    tick();
    or2 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++; if (ir2 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", ir2); end
    tests++; if (ov2 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", ov2); end
    tests++; if (bin2 !== 7'd0) begin fails++; $display("FAIL reset_dato_bin got %h want 00", bin2); end
    tests++; if ({err2, ovf2} !== 2'b00) begin fails++; $display("FAIL reset_err_ovf got %b want 00", {err2, ovf2}); end
    #9;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    int cyc;
    start2(8'h00, cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL zero_latency got %0d want 2", cyc); end
    tests++; if (bin2 !== 7'd0) begin fails++; $display("FAIL zero_bin got %h want 00", bin2); end
    tests++; if ({err2, ovf2} !== 2'b00) begin fails++; $display("FAIL zero_flags got %b want 00", {err2, ovf2}); end
    release2();
    tests++; if (ov2 !== 1'b0 || ir2 !== 1'b1) begin fails++; $display("FAIL zero_release got ov=%b ir=%b want ov=0 ir=1", ov2, ir2); end
  endtask

  task automatic test_values();
    int cyc;
    start2(8'h99, cyc);
    tests++; if (bin2 !== 7'h63 || ovf2 !== 1'b0) begin fails++; $display("FAIL val_99 got %h ovf=%b want 63 ovf=0", bin2, ovf2); end
    release2();
    start2(8'h59, cyc);
    tests++; if (bin2 !== 7'h3B || cyc !== 2) begin fails++; $display("FAIL val_59 got %h cyc=%0d want 3b cyc=2", bin2, cyc); end
    release2();
  endtask

  task automatic test_nibble();
    int cyc;
    start2(8'h1A, cyc);
    tests++; if (cyc !== 2) begin fails++; $display("FAIL nib_latency got %0d want 2", cyc); end
`ifdef CONV_BCD_CHECK_EN
    tests++; if (bin2 !== 7'h7F || err2 !== 1'b1) begin fails++; $display("FAIL nib_1a got %h err=%b want 7f err=1", bin2, err2); end
`else
    tests++; if (bin2 !== 7'd20 || err2 !== 1'b0) begin fails++; $display("FAIL nib_1a got %h err=%b want 14 err=0", bin2, err2); end
`endif
    release2();
  endtask

  task automatic test_stall();
    int cyc;
    start2(8'h37, cyc);
    iv2  = 1'b1;          // must be ignored while not IDLE
    bcd2 = 8'h11;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (ov2 !== 1'b1 || bin2 !== 7'h25 || ir2 !== 1'b0) begin
        fails++;
        $display("FAIL stall_%0d got ov=%b bin=%h ir=%b want ov=1 bin=25 ir=0", i, ov2, bin2, ir2);
      end
    end
    iv2 = 1'b0;
    release2();
    tests++; if (ov2 !== 1'b0 || ir2 !== 1'b1) begin fails++; $display("FAIL stall_release got ov=%b ir=%b want ov=0 ir=1", ov2, ir2); end
  endtask

  // in_valid and out_ready held high: IDLE, N CONV cycles and DONE give N+2 edges per word.
  task automatic test_back_to_back();
    int n_acc, first, second;
    n_acc = 0; first = -1; second = -1;
    iv2 = 1'b1; or2 = 1'b1; bcd2 = 8'h12;
    for (int e = 0; e < 12; e++) begin
      if (ir2) begin
        n_acc++;
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      tick();
    end
    iv2 = 1'b0; or2 = 1'b0;
    tests++; if (n_acc !== 3) begin fails++; $display("FAIL b2b_accepts got %0d want 3", n_acc); end
    tests++; if (second - first !== 4) begin fails++; $display("FAIL b2b_spacing got %0d want 4", second - first); end
    tests++; if (bin2 !== 7'd12) begin fails++; $display("FAIL b2b_value got %h want 0c", bin2); end
  endtask

  task automatic test_wide();
    int cyc;
    iv4 = 1'b1; bcd4 = 16'h9999;
    iv3 = 1'b1; bcd3 = 12'h128;
    tick();
    iv4 = 1'b0; iv3 = 1'b0;
    cyc = 0;
    while (!ov4 && cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 3) begin
        tests++;
        if (ov3 !== 1'b1 || bin3 !== 7'h7F || ovf3 !== 1'b1) begin
          fails++;
          $display("FAIL n3_128 got ov=%b bin=%h ovf=%b want ov=1 bin=7f ovf=1", ov3, bin3, ovf3);
        end
      end
    end
    tests++; if (cyc !== 4) begin fails++; $display("FAIL n4_latency got %0d want 4", cyc); end
    tests++; if (bin4 !== 14'd9999 || ovf4 !== 1'b0 || err4 !== 1'b0) begin fails++; $display("FAIL n4_9999 got %0d ovf=%b want 9999 ovf=0", bin4, ovf4); end
    or3 = 1'b1; or4 = 1'b1;
    tick();
    or3 = 1'b0; or4 = 1'b0;
    tests++; if (ir3 !== 1'b1 || ir4 !== 1'b1) begin fails++; $display("FAIL wide_release got ir3=%b ir4=%b want 1 1", ir3, ir4); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    iv2 = 1'b1; bcd2 = 8'h77;
    tick();               // accepted; now in first CONV cycle
    iv2 = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++; if (ir2 !== 1'b1 || ov2 !== 1'b0) begin fails++; $display("FAIL rstmid_hs got ir=%b ov=%b want ir=1 ov=0", ir2, ov2); end
    tests++; if (bin2 !== 7'd0) begin fails++; $display("FAIL rstmid_bin got %h want 00", bin2); end
    #3 rst = 1'b0;
    tick();
    start2(8'h42, cyc);
    tests++; if (bin2 !== 7'h2A || cyc !== 2) begin fails++; $display("FAIL rstmid_42 got %h cyc=%0d want 2a cyc=2", bin2, cyc); end
    release2();
  endtask

  initial begin
    iv2 = 1'b0; or2 = 1'b0; bcd2 = '0;
    iv4 = 1'b0; or4 = 1'b0; bcd4 = '0;
    iv3 = 1'b0; or3 = 1'b0; bcd3 = '0;
    test_reset();
    test_zero();
    test_values();
    test_nibble();
    test_stall();
    test_back_to_back();
    test_wide();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
